// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined integer ALU: opcode width and opcode encodings.
// SLT/SLTU encodings are reserved here even when the comparator is compiled out.
package alu_pkg;

  localparam int OP_W = 4;

  // ADD..AND keep the legacy encodings; SUB..SLTU are appended.
  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd1;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd2;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd4;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, arg1, arg2) -> result, modulo 2^XLEN.
// Define ALU_CMP_EN to build SLT/SLTU; otherwise opcodes 8/9 yield 0 like any undefined opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] arg1,
  input  logic [XLEN-1:0] arg2,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = arg2[SH_W-1:0];

  always_comb begin
    // NOTE: default assigned first so every path drives result; no latch is inferred.
    result = '0;
    case (op)
      ALU_ADD:  result = arg1 + arg2;
      ALU_SUB:  result = arg1 - arg2;
      ALU_SLL:  result = arg1 << shamt;
      ALU_SRL:  result = arg1 >> shamt;
      ALU_SRA:  result = $signed(arg1) >>> shamt;
      ALU_XOR:  result = arg1 ^ arg2;
      ALU_OR:   result = arg1 | arg2;
      ALU_AND:  result = arg1 & arg2;
`ifdef ALU_CMP_EN
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(arg1) < $signed(arg2))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (arg1 < arg2)};
`endif
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU functional unit: valid/ready issue, DEPTH register stages, collapsing bubbles,
// back-pressure from out_ready and single-cycle flush. Optional compare ops via ALU_CMP_EN.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_arg1,
  input  logic [XLEN-1:0]  in_arg2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  // Pipe entry; widths follow this instance's parameters, which a package cannot carry.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           stage [DEPTH];
  entry_t           feed  [DEPTH];
  logic [DEPTH-1:0] load;
  logic [XLEN-1:0]  core_result;

  alu_core #(.XLEN(XLEN)) u_core (
    .op     (in_op),
    .arg1   (in_arg1),
    .arg2   (in_arg2),
    .result (core_result)
  );

  // Stage k may load when any stage from k to the end has a hole, or the last stage drains.
  // This is the unrolled form of "k empty, or k advances", with no combinational chain.
  always_comb begin
    load = '0;
    for (int k = 0; k < DEPTH; k++) begin
      load[k] = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!stage[j].valid) load[k] = 1'b1;
      end
    end
  end

  always_comb begin
    feed[0] = '{valid: in_valid, result: core_result, tag: in_tag};
    for (int k = 1; k < DEPTH; k++) feed[k] = stage[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload is cleared along with valid because out_result/out_tag must read 0 after reset.
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) stage[k] <= feed[k];
      end
      // Flush only kills valid bits; an op presented this cycle is therefore never accepted.
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) stage[k].valid <= 1'b0;
      end
    end
  end

  assign in_ready   = load[0];
  assign out_valid  = stage[DEPTH-1].valid;
  assign out_result = stage[DEPTH-1].result;
  assign out_tag    = stage[DEPTH-1].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: scoreboard against a behavioural ALU model plus directed
// scenarios (latency, streaming, back-pressure, flush, XLEN=8/DEPTH=1 instance).
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 6;

`ifdef ALU_CMP_EN
  localparam logic [31:0] SLT_EXP = 32'd1;
`else
  localparam logic [31:0] SLT_EXP = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, flush, out_valid, out_ready;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_arg1, in_arg2, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [OP_W-1:0]  s_in_op;
  logic [7:0]       s_in_arg1, s_in_arg2, s_out_result;
  logic [TAG_W-1:0] s_in_tag, s_out_tag;

  int checks   = 0;
  int failures = 0;
  int deliveries = 0;
  int run_len = 0;
  int max_run = 0;

  typedef struct {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [13] = '{
    '{4'd0,  32'd5,          32'd2,  6'd3,  32'd7},
    '{4'd6,  32'd5,          32'd7,  6'd4,  32'hFFFF_FFFE},
    '{4'd1,  32'd1,          32'd12, 6'd5,  32'd4096},
    '{4'd2,  32'd4,          32'd1,  6'd6,  32'd2},
    '{4'd7,  32'h8000_0000,  32'd4,  6'd7,  32'hF800_0000},
    '{4'd3,  32'b1010,       32'b1001, 6'd8, 32'b0011},
    '{4'd4,  32'b1100,       32'b0011, 6'd9, 32'b1111},
    '{4'd5,  32'b1010,       32'b1001, 6'd10, 32'b1000},
    '{4'd8,  32'hFFFF_FFFF,  32'd1,  6'd11, SLT_EXP},
    '{4'd9,  32'hFFFF_FFFF,  32'd1,  6'd12, 32'd0},
    '{4'd12, 32'd5,          32'd3,  6'd13, 32'd0},
    '{4'd1,  32'd1,          32'd33, 6'd14, 32'd2},
    '{4'd2,  32'h8000_0000,  32'd31, 6'd15, 32'd1}
  };

  alu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_arg1(in_arg1), .in_arg2(in_arg2), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  alu_pipe #(.XLEN(8), .DEPTH(1), .TAG_W(TAG_W)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
    .in_arg1(s_in_arg1), .in_arg2(s_in_arg2), .in_tag(s_in_tag), .flush(1'b0),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result), .out_tag(s_out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU written straight from the opcode rules, 32-bit.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = b % 32;
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
    case (op)
      4'd0: return a + b;
      4'd1: return a << sh;
      4'd2: return a >> sh;
      4'd3: return a ^ b;
      4'd4: return a | b;
      4'd5: return a & b;
      4'd6: return a - b;
      4'd7: return (a >> sh) | fill;
`ifdef ALU_CMP_EN
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard: deliveries checked first, then flush kill, then acceptance of the issued op.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      run_len = 0;
    end else begin
      if (out_valid && out_ready) begin
        deliveries++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got result %0h tag %0d expected nothing", out_result, out_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_result", out_result, e.result);
          check("sb_tag", out_tag, e.tag);
        end
      end else begin
        run_len = 0;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back('{result: alu_model(in_op, in_arg1, in_arg2), tag: in_tag});
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_op = op; in_arg1 = a; in_arg2 = b; in_tag = tag;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL out_timeout: got out_valid 0 expected 1 within 30 cycles");
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_arg1 = '0; in_arg2 = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_op = '0; s_in_arg1 = '0; s_in_arg2 = '0; s_in_tag = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    @(posedge clk); #1;

    // Directed ops, one at a time: model pinned by literals, DUT checked by the scoreboard.
    for (int i = 0; i < 13; i++) begin
      check("model_pin", alu_model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_out(n);
      check("latency", n, DEPTH);
    end

    // Streaming: eight back-to-back ADDs must leave the pipe on consecutive cycles.
    max_run = 0;
    for (int i = 0; i < 8; i++) send(ALU_ADD, i, i, i[TAG_W-1:0]);
    repeat (4) @(posedge clk); #1;
    check("stream_run", max_run >= 8, 1);

    // Back-pressure: two accepted, third blocked, output frozen on the first result.
    out_ready = 1'b0;
    send(ALU_ADD, 32'd10, 32'd1, 6'd20);
    send(ALU_SUB, 32'd10, 32'd1, 6'd21);
    in_valid = 1'b1; in_op = ALU_XOR; in_arg1 = 32'd6; in_arg2 = 32'd3; in_tag = 6'd22;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_result", out_result, 11);
    check("bp_out_tag", out_tag, 20);
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_result", out_result, 11);
      check("bp_hold_tag", out_tag, 20);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_rise", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Flush with a full pipe; the head is handed off in the flush cycle and still counts.
    out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, 6'd30);
    send(ALU_ADD, 32'd2, 32'd2, 6'd31);
    out_ready = 1'b1; flush = 1'b1;
    in_valid = 1'b1; in_op = ALU_ADD; in_arg1 = 32'd100; in_arg2 = 32'd100; in_tag = 6'd32;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    send(ALU_ADD, 32'd7, 32'd8, 6'd33);
    wait_out(n);
    check("flush_next_latency", n, DEPTH);
    repeat (4) @(posedge clk); #1;
    check("drained", exp_q.size(), 0);
    check("delivery_count", deliveries, 13 + 8 + 3 + 1 + 1);

    // XLEN=8, DEPTH=1: wraparound and single-cycle latency.
    s_in_valid = 1'b1; s_in_op = ALU_ADD; s_in_arg1 = 8'hFF; s_in_arg2 = 8'h01; s_in_tag = 6'd5;
    @(negedge clk);
    check("w8_in_ready", s_in_ready, 1);
    @(posedge clk); #1 s_in_valid = 1'b0;
    @(negedge clk);
    check("w8_out_valid", s_out_valid, 1);
    check("w8_out_result", s_out_result, 8'h00);
    check("w8_out_tag", s_out_tag, 5);
    @(negedge clk);
    check("w8_out_valid_drop", s_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected finish");
    $fatal(1, "timeout");
  end

endmodule
